mem_lsu_stage: RTL

- Pipeline MEM stage with a built-in byte-serial load/store unit.
- Sits between EX_MEM and MEM_WB. Non-memory instructions pass through with registered outputs.
- Loads and stores run over a shared 8-bit memory port. The port is granted by the memory controller, which arbitrates it against IF.
- While an access is in flight, the stage stalls the front of the pipeline and emits bubbles to MEM_WB.

---
 rtl/mem_lsu_stage_pkg.sv | 31 +++
 rtl/mem_lsu_stage_if.sv | 21 ++
 rtl/mem_load_extend.sv | 39 +++
 rtl/mem_lsu_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_stage_pkg.sv
// Shared types and constants for the MEM stage load/store unit.
package mem_lsu_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned FUNCT3_UNS_BIT = 2;
  localparam int unsigned CNT_W          = 3;

  localparam logic        WRITE_DISABLE = 1'b0;
  localparam int unsigned REG_NOP       = 0;
  localparam int unsigned ZERO          = 0;

  // Number of bytes moved for a size code; code 3 behaves as a word.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return CNT_W'(1);
      SIZE_H:  return CNT_W'(2);
      SIZE_W:  return CNT_W'(4);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_stage_if.sv
// Byte-wide memory port shared with IF through the memory controller.
interface mem_lsu_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [7:0]        mem_wdata_out;
  logic              mem_gnt_in;
  logic [7:0]        mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_gnt_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_gnt_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_load_extend.sv
// Sign/zero extension of an assembled load value to the register width.
module mem_load_extend
  import mem_lsu_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] bytes_in,
  input  logic [1:0]        size_in,
  input  logic              uns_in,
  output logic [DATA_W-1:0] data_c
);

  int unsigned       nbits;
  logic              fill;
  logic [DATA_W-1:0] mask;

  // Keep the loaded bits, replicate the sign bit (or zero) above them.
  always_comb begin
    case (size_in)
      SIZE_B: begin
        nbits = 8;
        fill  = bytes_in[7];
      end
      SIZE_H: begin
        nbits = 16;
        fill  = bytes_in[15];
      end
      default: begin
        nbits = 32;
        fill  = bytes_in[31];
      end
    endcase
    if (uns_in) fill = 1'b0;
    // 1<<DATA_W wraps to 0, so a full-width load yields an all-ones mask.
    mask   = (DATA_W'(1) << nbits) - DATA_W'(1);
    data_c = (bytes_in & mask) | (fill ? ~mask : '0);
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// Pipeline MEM stage: passthrough for ALU ops, byte-serial load/store engine.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic                 rdE_in,
  input  logic [REG_IDX_W-1:0] rdIdx_in,
  input  logic [DATA_W-1:0]    rdData_in,
  input  logic                 memRd_in,
  input  logic                 memWr_in,
  input  logic [2:0]           memOp_in,
  input  logic [ADDR_W-1:0]    memAddr_in,
  input  logic [DATA_W-1:0]    storeData_in,
  mem_lsu_stage_if.master      mem,
  output logic                 stall_out,
  output logic                 rdE_out,
  output logic [REG_IDX_W-1:0] rdIdx_out,
  output logic [DATA_W-1:0]    rdData_out
);

  localparam int unsigned MAX_BYTES = DATA_W / 8;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     gcnt_q, gcnt_d;
  logic [CNT_W-1:0]     rcnt_q, rcnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 store_q, store_d;
  logic                 rde_q, rde_d;
  logic [REG_IDX_W-1:0] ridx_q, ridx_d;
  logic [DATA_W-1:0]    sdata_q, sdata_d;
  logic [DATA_W-1:0]    bytes_q, bytes_d;
  logic                 out_rde_d;
  logic [REG_IDX_W-1:0] out_ridx_d;
  logic [DATA_W-1:0]    out_rdata_d;

  logic [DATA_W-1:0]    bytes_c;
  logic [DATA_W-1:0]    ext_c;
  logic [7:0]           wbyte_c;
  logic                 memop_c;
  logic                 last_gnt_c;
  logic                 stall_c;
  logic                 req_c;
  logic                 we_c;

  mem_load_extend #(.DATA_W(DATA_W)) u_ext (
    .bytes_in (bytes_c),
    .size_in  (size_q),
    .uns_in   (uns_q),
    .data_c   (ext_c)
  );

  // Merge the incoming read byte into its lane and pick the byte to write.
  always_comb begin
    bytes_c = bytes_q;
    wbyte_c = 8'h00;
    for (int unsigned l = 0; l < MAX_BYTES; l++) begin
      if (rd_pend_q && (rcnt_q == CNT_W'(l))) bytes_c[8*l +: 8] = mem.mem_rdata_in;
      if (gcnt_q == CNT_W'(l)) wbyte_c = sdata_q[8*l +: 8];
    end
  end

  // Next-state, datapath updates and port/stall outputs.
  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    rcnt_d      = rd_pend_q ? rcnt_q + CNT_W'(1) : rcnt_q;
    rd_pend_d   = 1'b0;
    base_d      = base_q;
    size_d      = size_q;
    uns_d       = uns_q;
    store_d     = store_q;
    rde_d       = rde_q;
    ridx_d      = ridx_q;
    sdata_d     = sdata_q;
    bytes_d     = bytes_c;
    out_rde_d   = WRITE_DISABLE;
    out_ridx_d  = REG_IDX_W'(REG_NOP);
    out_rdata_d = DATA_W'(ZERO);
    stall_c     = 1'b0;
    req_c       = 1'b0;
    we_c        = 1'b0;

    memop_c    = valid_in && (memRd_in || memWr_in);
    last_gnt_c = (state_q == S_XFER) && mem.mem_gnt_in
                 && (gcnt_q == size_bytes(size_q) - CNT_W'(1));

    case (state_q)
      S_IDLE: begin
        if (memop_c) begin
          base_d  = memAddr_in;
          size_d  = memOp_in[1:0];
          uns_d   = memOp_in[FUNCT3_UNS_BIT];
          store_d = memWr_in;
          rde_d   = rdE_in;
          ridx_d  = rdIdx_in;
          sdata_d = storeData_in;
          bytes_d = '0;
          gcnt_d  = '0;
          rcnt_d  = '0;
          stall_c = 1'b1;
          state_d = S_XFER;
        end else if (valid_in) begin
          out_rde_d   = rdE_in;
          out_ridx_d  = rdIdx_in;
          out_rdata_d = rdData_in;
        end
      end
      S_XFER: begin
        req_c   = 1'b1;
        we_c    = store_q;
        stall_c = !(store_q && last_gnt_c);
        if (mem.mem_gnt_in) begin
          gcnt_d    = gcnt_q + CNT_W'(1);
          rd_pend_d = !store_q;
        end
        if (last_gnt_c) state_d = store_q ? S_IDLE : S_LAST;
      end
      S_LAST: begin
        out_rde_d   = rde_q;
        out_ridx_d  = ridx_q;
        out_rdata_d = ext_c;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req_out   = req_c;
  assign mem.mem_we_out    = we_c;
  assign mem.mem_addr_out  = base_q + ADDR_W'(gcnt_q);
  assign mem.mem_wdata_out = wbyte_c;
  // Reset drops the stall at once, even if EX_MEM still shows a memory op.
  assign stall_out         = rst_in && stall_c;

  // State and pipeline registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      gcnt_q     <= '0;
      rcnt_q     <= '0;
      rd_pend_q  <= 1'b0;
      base_q     <= '0;
      size_q     <= SIZE_B;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      rde_q      <= 1'b0;
      ridx_q     <= '0;
      sdata_q    <= '0;
      bytes_q    <= '0;
      rdE_out    <= WRITE_DISABLE;
      rdIdx_out  <= REG_IDX_W'(REG_NOP);
      rdData_out <= DATA_W'(ZERO);
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      rcnt_q     <= rcnt_d;
      rd_pend_q  <= rd_pend_d;
      base_q     <= base_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      store_q    <= store_d;
      rde_q      <= rde_d;
      ridx_q     <= ridx_d;
      sdata_q    <= sdata_d;
      bytes_q    <= bytes_d;
      rdE_out    <= out_rde_d;
      rdIdx_out  <= out_ridx_d;
      rdData_out <= out_rdata_d;
    end
  end

endmodule
